// File: rtl/xor_stream_parity.sv
// xor_stream_parity: frame-level XOR parity generator with valid/ready on both sides.
// Accumulates a bitwise XOR of WIDTH-bit words until a word flagged last, then holds
// the column parity word, its reduction bit and a saturating word count until taken.
// Optional feature macro: XOR_PARITY_CHECK_EN -- treats the last word as a check word,
// adds out_err (non-zero residue) and a saturating err_cnt of erroneous frames.
module xor_stream_parity #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_parity,
    output logic             out_bit,
    output logic [CNT_W-1:0] out_count
`ifdef XOR_PARITY_CHECK_EN
    ,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept;
    logic             retire;

    // Counter increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Handshake decode: everything here comes from registered state, so there is
    // no combinational path from the input side or out_ready to the outputs.
    assign in_ready   = (state != HOLD);
    assign out_valid  = (state == HOLD);
    assign accept     = in_valid && in_ready;
    assign retire     = out_valid && out_ready;

    // acc and cnt are zero in IDLE, so they can drive the result ports directly.
    assign out_parity = acc;
    assign out_bit    = ^acc;
    assign out_count  = cnt;

    // State, accumulator and counter registers; reset discards any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and datapath update: start, extend or retire a frame.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    acc_nxt   = in_data;
                    cnt_nxt   = CNT_ONE;
                    state_nxt = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_nxt   = acc ^ in_data;
                    cnt_nxt   = sat_inc(cnt);
                    state_nxt = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                acc_nxt   = '0;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef XOR_PARITY_CHECK_EN
    // With the last word acting as a check word, a clean frame leaves a zero residue.
    assign out_err = |acc;

    // Count retired frames that carried a non-zero residue; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (retire && out_err) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule
